// File: rtl/mul_datapath_if.sv
// mul_datapath_if
//   Bundles the operand bus, the controller strobes and the datapath status
//   outputs of mul_datapath. W is the operand width; product/result are 2W.
//   master : the controller side (drives data_in and the strobes).
//   slave  : the datapath side (drives eqz, product, result, result_valid, busy).
//
// Control semantics: there is no valid/ready pair. Every strobe is a level
// sampled on the rising clock edge and acts on that edge only; the datapath
// never back-pressures. eqz is a combinational status that the controller
// reads in the same cycle to decide whether to keep issuing ld_d/dec.
interface mul_datapath_if #(
  parameter int W = 16
);
  logic [W-1:0]   data_in;
  logic           ld_a;
  logic           ld_b;
  logic           ld_d;
  logic           clr_d;
  logic           dec;
  logic           done;
  logic           eqz;
  logic [2*W-1:0] product;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic           busy;

  modport master (
    output data_in, ld_a, ld_b, ld_d, clr_d, dec, done,
    input  eqz, product, result, result_valid, busy
  );

  modport slave (
    input  data_in, ld_a, ld_b, ld_d, clr_d, dec, done,
    output eqz, product, result, result_valid, busy
  );
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath
//   Datapath of a repeated-addition multiplier. A holds the multiplicand,
//   B counts the remaining additions, P accumulates A once per ld_d cycle.
//   A rising edge on the controller's done level captures the final product
//   into result and pulses result_valid for one cycle.
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - asynchronous, active-high reset
//   bus    - mul_datapath_if slave modport (operand bus, strobes, status)
module mul_datapath #(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mul_datapath_if.slave       bus
);

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] p_q, p_d;
  logic [2*W-1:0] result_q, result_d;
  logic           result_valid_q, result_valid_d;
  logic           busy_q, busy_d;
  logic           done_q;

  logic           b_zero;
  logic           ld_d_eff;
  logic           done_rise;
  logic [2*W-1:0] p_plus_a;

  assign b_zero    = (b_q == '0);
  // A zero multiplier still gets one ld_d/dec cycle from the controller;
  // gating ld_d on B keeps that cycle from adding A into P.
  assign ld_d_eff  = bus.ld_d && !b_zero && !bus.clr_d;
  assign done_rise = bus.done && !done_q;
  assign p_plus_a  = p_q + {{W{1'b0}}, a_q};

  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    p_d            = p_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = bus.ld_d || bus.dec;

    if (bus.ld_a) begin
      a_d = bus.data_in;
    end

    // dec saturates at zero rather than wrapping to all-ones.
    if (bus.ld_b) begin
      b_d = bus.data_in;
    end else if (bus.dec && !b_zero) begin
      b_d = b_q - 1'b1;
    end

    if (bus.clr_d) begin
      p_d = '0;
    end else if (ld_d_eff) begin
      p_d = p_plus_a;
    end

    // Capture what P will hold after this edge, so a done raised together
    // with the last accumulate cycle still sees the final sum.
    if (done_rise) begin
      result_d       = ld_d_eff ? p_plus_a : p_q;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q            <= '0;
      b_q            <= '0;
      p_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      a_q            <= a_d;
      b_q            <= b_d;
      p_q            <= p_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      done_q         <= bus.done;
    end
  end

  assign bus.eqz          = b_zero;
  assign bus.product      = p_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mul_datapath.sv
module tb_mul_datapath;
  localparam int W = 16;
  localparam int BUDGET = 70000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_datapath_if #(.W(W)) bus ();

  mul_datapath #(.W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rv_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops one expected result for every result_valid cycle.
  always @(negedge clk) begin
    if (!rst && bus.result_valid === 1'b1) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        check("rv_unexpected", {63'd0, bus.result_valid}, 64'd0);
      end else begin
        check("result_pop", {32'd0, bus.result}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_a  = 1'b0;
    bus.ld_b  = 1'b0;
    bus.ld_d  = 1'b0;
    bus.clr_d = 1'b0;
    bus.dec   = 1'b0;
    bus.done  = 1'b0;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    bus.data_in = v;
    bus.ld_a = 1'b1;
    tick();
    bus.ld_a = 1'b0;
  endtask

  task automatic load_b_clear(input logic [W-1:0] v);
    bus.data_in = v;
    bus.ld_b  = 1'b1;
    bus.clr_d = 1'b1;
    tick();
    bus.ld_b  = 1'b0;
    bus.clr_d = 1'b0;
  endtask

  // Issue ld_d+dec until eqz, always at least one cycle, bounded.
  task automatic accumulate(input int exp_cycles, input string tag);
    int n = 0;
    bus.ld_d = 1'b1;
    bus.dec  = 1'b1;
    do begin
      tick();
      n++;
    end while (bus.eqz !== 1'b1 && n < BUDGET);
    bus.ld_d = 1'b0;
    bus.dec  = 1'b0;
    check(tag, n, exp_cycles);
  endtask

  task automatic pulse_done(input logic [2*W-1:0] exp);
    exp_q.push_back(exp);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rv_before;
    logic [W-1:0] ra, rb;
    idle();
    bus.data_in = '0;

    // Reset state, checked before any clock edge.
    #1;
    check("rst_product", bus.product, 0);
    check("rst_result", bus.result, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_eqz", bus.eqz, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 7 x 5
    load_a(16'd7);
    load_b_clear(16'd5);
    check("b5_eqz_low", bus.eqz, 0);
    accumulate(5, "b5_cycles");
    check("b5_product", bus.product, 35);
    pulse_done(32'd35);
    check("b5_result", bus.result, 35);
    check("b5_rv_low", bus.result_valid, 0);

    // Zero multiplier: one ld_d/dec cycle is issued and must do nothing.
    load_a(16'd9);
    load_b_clear(16'd0);
    accumulate(1, "b0_cycles");
    check("b0_eqz", bus.eqz, 1);
    check("b0_product", bus.product, 0);
    check("b0_busy", bus.busy, 1);
    pulse_done(32'd0);
    check("b0_result", bus.result, 0);
    check("idle_busy", bus.busy, 0);

    // ld_b has priority over dec; clr_d has priority over ld_d.
    load_a(16'd5);
    load_b_clear(16'd0);
    bus.data_in = 16'd3;
    bus.ld_b = 1'b1;
    bus.dec  = 1'b1;
    tick();
    idle();
    check("ldb_dec_eqz", bus.eqz, 0);
    accumulate(3, "ldb_dec_cycles");
    check("ldb_dec_product", bus.product, 15);
    bus.clr_d = 1'b1;
    bus.ld_d  = 1'b1;
    tick();
    idle();
    check("clr_ld_product", bus.product, 0);
    // dec at B=0 saturates and idle strobes leave P alone.
    bus.dec = 1'b1;
    tick();
    idle();
    check("dec_sat_eqz", bus.eqz, 1);
    tick();
    check("hold_result", bus.result, 0);

    // done raised on the final accumulate edge captures P + A.
    load_a(16'd4);
    load_b_clear(16'd2);
    bus.ld_d = 1'b1;
    bus.dec  = 1'b1;
    tick();
    exp_q.push_back(32'd8);
    bus.done = 1'b1;
    tick();
    idle();
    tick();
    check("late_done_product", bus.product, 8);
    check("late_done_result", bus.result, 8);

    // A few random small operands.
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(0, 300));
      rb = 16'($urandom_range(1, 40));
      load_a(ra);
      load_b_clear(rb);
      accumulate(int'(rb), "rand_cycles");
      check("rand_product", bus.product, 32'(ra) * 32'(rb));
      pulse_done(32'(ra) * 32'(rb));
    end

    // done held high for 10 cycles gives one pulse only.
    rv_before = rv_count;
    exp_q.push_back(bus.product);
    bus.done = 1'b1;
    repeat (10) tick();
    bus.done = 1'b0;
    tick();
    tick();
    check("done_held_pulses", rv_count - rv_before, 1);

    // Full-scale operands, no wrap.
    load_a(16'hFFFF);
    load_b_clear(16'hFFFF);
    accumulate(65535, "max_cycles");
    check("max_product", bus.product, 32'hFFFE0001);
    pulse_done(32'hFFFE0001);
    check("max_result", bus.result, 32'hFFFE0001);

    // Reset mid-run at B=4, P=12.
    load_a(16'd3);
    load_b_clear(16'd8);
    bus.ld_d = 1'b1;
    bus.dec  = 1'b1;
    repeat (4) tick();
    idle();
    check("pre_rst_product", bus.product, 12);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("mid_rst_product", bus.product, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_eqz", bus.eqz, 1);
    check("mid_rst_rv", bus.result_valid, 0);
    tick();
    load_a(16'd3);
    load_b_clear(16'd2);
    accumulate(2, "post_rst_cycles");
    pulse_done(32'd6);
    check("post_rst_result", bus.result, 6);

    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter W, default 16: operand width in bits.
REQ-003 Port list:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  W  shared operand bus.
- ld_a  in  1  load multiplicand register A from data_in.
- ld_b  in  1  load multiplier/count register B from data_in.
- ld_d  in  1  accumulate: P <= P + A.
- clr_d  in  1  clear accumulator P.
- dec  in  1  decrement B.
- done  in  1  controller done level.
- eqz  out  1  B equals zero (combinational from B).
- product  out  2W  accumulator P.
- result  out  2W  captured final product.
- result_valid  out  1  one-cycle pulse when result is captured.
- busy  out  1  accumulation in progress.

Function
REQ-004 A SHALL be a W-bit register, loaded from data_in on clk when ld_a=1, and holding otherwise.
REQ-005 B SHALL be a W-bit register with this priority: ld_b (B <= data_in) over dec (B <= B-1) over hold.
REQ-006 dec SHALL saturate: with B=0, dec leaves B at 0 (no wrap to all-ones).
REQ-007 P SHALL be a 2W-bit register with this priority: clr_d (P <= 0) over ld_d (P <= P + A, zero-extended) over hold.
REQ-008 ld_d SHALL be suppressed when B=0 in the same cycle, so a zero multiplier yields product 0 even though the controller issues one ld_d/dec cycle.
REQ-009 eqz SHALL equal (B == 0) combinationally, with no register stage, and be valid in the same cycle B changes.
REQ-010 Accumulation SHALL never overflow: P holds at most (2^W-1)^2 < 2^(2W).
REQ-011 ld_a and ld_b asserted together SHALL load A and B from the same data_in value.
REQ-012 busy SHALL be 1 in any cycle where ld_d=1 or dec=1, registered (visible the cycle after), and 0 otherwise.
REQ-013 A done rising-edge detector SHALL use a registered copy done_q.
REQ-014 On the first clk edge with done=1 and done_q=0: result <= P (or P + A if ld_d is effective that edge), and result_valid is 1 for exactly one cycle.
REQ-015 result SHALL hold its value until the next done rising edge. done held high SHALL NOT re-pulse result_valid.
REQ-016 Latency from the ld_b load edge to eqz=1 SHALL be exactly N dec cycles for multiplier N. After those cycles, P = A*N.
REQ-017 Asserted control signals with no load/accumulate effect SHALL leave all registers unchanged.

Reset
REQ-018 rst=1 SHALL immediately, without waiting for clk, force A=0, B=0, P=0, result=0, result_valid=0, busy=0, done_q=0. eqz is consequently 1.
REQ-019 rst asserted mid-accumulation SHALL abort the operation. After release, the block SHALL accept a fresh ld_a/ld_b sequence with no residual state.
REQ-020 rst deassertion SHALL take effect synchronously at the next clk edge. No register update occurs on the release edge if rst is still high at that edge.

Verification
REQ-021 A=7, B=5 (ld_a, then ld_b+clr_d, then ld_d+dec until eqz) -> eqz rises after 5 dec cycles, product=35, done edge gives result=35 and a 1-cycle result_valid.
REQ-022 B=0, A=9, with one ld_d+dec cycle issued -> B stays 0, product=0, result=0.
REQ-023 A=B=16'hFFFF -> after 65535 accumulate cycles, product=32'hFFFE0001 with no wrap.
REQ-024 ld_b and dec in the same cycle with data_in=3 -> B=3. clr_d and ld_d together -> P=0.
REQ-025 rst pulsed for 1 ns mid-run (B=4, P=12) -> all outputs zero immediately, eqz=1. A next run with A=3, B=2 -> result=6.
REQ-026 done held high for 10 cycles -> result_valid high in exactly one cycle.
